unified_mem_arbiter: RTL and testbench

Sequences a single-port unified memory shared between the instruction fetch path and the data memory path of the NAND CPU. It accepts at most one transaction at a time, arbitrates fetch vs. data requests round-robin, tracks the fixed memory latency with a counter, and returns a one-cycle response pulse to the requester that was granted. It sits between fetch_unit/d_mem and the memory macro. It is the source of the structural-hazard stall when both paths want memory.

---
 rtl/unified_mem_arbiter.sv | 123 ++++++++++++
 tb/tb_unified_mem_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// Single-port memory sequencer shared by instruction fetch and data access.
// Round-robin arbitration, one outstanding transaction, fixed-latency response pulse.
module unified_mem_arbiter #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  localparam int unsigned CNT_W = 4;
  localparam logic SRC_FETCH = 1'b0;
  localparam logic SRC_DATA  = 1'b1;

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               owner_q, owner_d;
  logic               owner_we_q, owner_we_d;
  logic               last_gnt_q, last_gnt_d;
  logic               complete;
  logic               issue_ok;
  logic               issue;
  logic               win;

  // Next-state, arbitration and response generation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    owner_we_d  = owner_we_q;
    last_gnt_d  = last_gnt_q;
    if_gnt_o    = 1'b0;
    if_rvalid_o = 1'b0;
    if_rdata_o  = '0;
    d_gnt_o     = 1'b0;
    d_rvalid_o  = 1'b0;
    d_rdata_o   = '0;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;

    complete = !rst_i && (state_q == S_WAIT) && (cnt_q == CNT_W'(1));
    issue_ok = !rst_i && ((state_q == S_IDLE) || complete);
    // On a tie the requester that did not win last time goes next
    win      = (if_req_i && d_req_i) ? ~last_gnt_q : d_req_i;
    issue    = issue_ok && (if_req_i || d_req_i);
    busy_o   = !rst_i && (state_q == S_WAIT);

    if (complete) begin
      if (owner_q == SRC_DATA) begin
        d_rvalid_o = 1'b1;
        d_rdata_o  = owner_we_q ? '0 : mem_rdata_i;
      end else begin
        if_rvalid_o = 1'b1;
        if_rdata_o  = mem_rdata_i;
      end
    end

    if (state_q == S_WAIT) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        state_d = S_IDLE;
      end
    end

    if (issue) begin
      mem_en_o = 1'b1;
      if (win == SRC_DATA) begin
        d_gnt_o     = 1'b1;
        mem_we_o    = d_we_i;
        mem_addr_o  = d_addr_i;
        mem_wdata_o = d_wdata_i;
      end else begin
        if_gnt_o   = 1'b1;
        mem_addr_o = if_addr_i;
      end
      owner_d    = win;
      owner_we_d = win & d_we_i;
      last_gnt_d = win;
      cnt_d      = CNT_W'(LATENCY);
      state_d    = S_WAIT;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      owner_q    <= SRC_FETCH;
      owner_we_q <= 1'b0;
      last_gnt_q <= SRC_DATA;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      owner_we_q <= owner_we_d;
      last_gnt_q <= last_gnt_d;
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: a LATENCY=2 and a LATENCY=1 instance, each checked
// every cycle against a transaction-level model, plus directed literal expectations.
module tb_unified_mem_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          if_req    [2];
  logic [AW-1:0] if_addr   [2];
  logic          if_gnt    [2];
  logic          if_rvalid [2];
  logic [DW-1:0] if_rdata  [2];
  logic          d_req     [2];
  logic          d_we      [2];
  logic [AW-1:0] d_addr    [2];
  logic [DW-1:0] d_wdata   [2];
  logic          d_gnt     [2];
  logic          d_rvalid  [2];
  logic [DW-1:0] d_rdata   [2];
  logic          mem_en    [2];
  logic          mem_we    [2];
  logic [AW-1:0] mem_addr  [2];
  logic [DW-1:0] mem_wdata [2];
  logic [DW-1:0] mem_rdata [2];
  logic          busy      [2];
  logic [DW-1:0] rd_q      [2];

  int n_chk  = 0;
  int n_pass = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    unified_mem_arbiter #(
      .ADDR_W (AW),
      .DATA_W (DW),
      .LATENCY((g == 0) ? 2 : 1)
    ) u_dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .if_req_i   (if_req[g]),
      .if_addr_i  (if_addr[g]),
      .if_gnt_o   (if_gnt[g]),
      .if_rvalid_o(if_rvalid[g]),
      .if_rdata_o (if_rdata[g]),
      .d_req_i    (d_req[g]),
      .d_we_i     (d_we[g]),
      .d_addr_i   (d_addr[g]),
      .d_wdata_i  (d_wdata[g]),
      .d_gnt_o    (d_gnt[g]),
      .d_rvalid_o (d_rvalid[g]),
      .d_rdata_o  (d_rdata[g]),
      .mem_en_o   (mem_en[g]),
      .mem_we_o   (mem_we[g]),
      .mem_addr_o (mem_addr[g]),
      .mem_wdata_o(mem_wdata[g]),
      .mem_rdata_i(mem_rdata[g]),
      .busy_o     (busy[g])
    );
    assign mem_rdata[g] = rd_q[g];
  end

  function automatic logic [DW-1:0] rdval(input logic [AW-1:0] a);
    return (a == 16'h0010) ? 16'h00A5 : (a ^ 16'h1000);
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  // Memory macro: read data registered at issue, held until the next read
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst && mem_en[k] && !mem_we[k]) rd_q[k] <= rdval(mem_addr[k]);
    end
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s[%0d] t=%0t: got %h expected %h", nm, k, $time, act, exp);
    else n_pass++;
  endtask

  // Transaction-level model: one pending transaction with an absolute due cycle
  int m_cyc [2] = '{0, 0};
  int m_due [2] = '{0, 0};
  bit m_pend[2] = '{1'b0, 1'b0};
  bit m_own [2] = '{1'b0, 1'b0};
  bit m_we  [2] = '{1'b0, 1'b0};
  bit m_last[2] = '{1'b1, 1'b1};
  bit sn_if [2] = '{1'b0, 1'b0};
  bit sn_d  [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit resp, can, win, iss;
      logic [DW-1:0] e_ifr, e_dr, e_wd;
      logic [AW-1:0] e_addr;
      resp = 1'b0; can = 1'b0; win = 1'b0; iss = 1'b0;
      if (!rst) begin
        resp = m_pend[k] && (m_cyc[k] == m_due[k]);
        can  = !m_pend[k] || resp;
        win  = (if_req[k] && d_req[k]) ? !m_last[k] : d_req[k];
        iss  = can && (if_req[k] || d_req[k]);
      end
      e_ifr  = (resp && !m_own[k]) ? mem_rdata[k] : '0;
      e_dr   = (resp && m_own[k] && !m_we[k]) ? mem_rdata[k] : '0;
      e_addr = !iss ? '0 : (win ? d_addr[k] : if_addr[k]);
      e_wd   = (iss && win) ? d_wdata[k] : '0;
      chk("if_gnt",    k, 32'(if_gnt[k]),    32'(iss && !win));
      chk("d_gnt",     k, 32'(d_gnt[k]),     32'(iss && win));
      chk("if_rvalid", k, 32'(if_rvalid[k]), 32'(resp && !m_own[k]));
      chk("d_rvalid",  k, 32'(d_rvalid[k]),  32'(resp && m_own[k]));
      chk("if_rdata",  k, 32'(if_rdata[k]),  32'(e_ifr));
      chk("d_rdata",   k, 32'(d_rdata[k]),   32'(e_dr));
      chk("mem_en",    k, 32'(mem_en[k]),    32'(iss));
      chk("mem_we",    k, 32'(mem_we[k]),    32'(iss && win && d_we[k]));
      chk("mem_addr",  k, 32'(mem_addr[k]),  32'(e_addr));
      chk("mem_wdata", k, 32'(mem_wdata[k]), 32'(e_wd));
      chk("busy",      k, 32'(busy[k]),      32'(!rst && m_pend[k]));
      sn_if[k] = if_gnt[k];
      sn_d[k]  = d_gnt[k];
      if (rst) begin
        m_pend[k] = 1'b0;
        m_last[k] = 1'b1;
      end else begin
        if (resp) m_pend[k] = 1'b0;
        if (iss) begin
          m_pend[k] = 1'b1;
          m_due[k]  = m_cyc[k] + lat(k);
          m_own[k]  = win;
          m_we[k]   = win && d_we[k];
          m_last[k] = win;
        end
      end
      m_cyc[k]++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if_req[k] = 1'b0; if_addr[k] = '0; d_req[k] = 1'b0; d_we[k] = 1'b0;
      d_addr[k] = '0; d_wdata[k] = '0;
    end
    cyc(); cyc();
    #1 chk("rst_busy", 0, 32'(busy[0]), 0);

    // Single fetch after reset
    cyc(); rst = 1'b0; if_req[0] = 1'b1; if_addr[0] = 16'h0010;
    #1 chk("a_gnt", 0, 32'(if_gnt[0]), 1); chk("a_en", 0, 32'(mem_en[0]), 1);
    chk("a_addr", 0, 32'(mem_addr[0]), 32'h0010); chk("a_we", 0, 32'(mem_we[0]), 0);
    cyc(); if_req[0] = 1'b0;
    #1 chk("a_busy1", 0, 32'(busy[0]), 1); chk("a_rv1", 0, 32'(if_rvalid[0]), 0);
    cyc();
    #1 chk("a_rv2", 0, 32'(if_rvalid[0]), 1); chk("a_rdata", 0, 32'(if_rdata[0]), 32'h00A5);
    chk("a_busy2", 0, 32'(busy[0]), 1);
    cyc();
    #1 chk("a_idle", 0, 32'(busy[0]), 0);

    // Outputs forced low during reset, then first tie goes to fetch
    cyc(); rst = 1'b1; if_req[0] = 1'b1; if_addr[0] = 16'h0020;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 16'h0030;
    #1 chk("r_ig", 0, 32'(if_gnt[0]), 0); chk("r_dg", 0, 32'(d_gnt[0]), 0);
    chk("r_en", 0, 32'(mem_en[0]), 0); chk("r_busy", 0, 32'(busy[0]), 0);
    cyc(); rst = 1'b0;
    #1 chk("b_ig", 0, 32'(if_gnt[0]), 1); chk("b_dg0", 0, 32'(d_gnt[0]), 0);
    cyc(); if_req[0] = 1'b0;
    #1 chk("b_dg1", 0, 32'(d_gnt[0]), 0);
    cyc();
    #1 chk("b_dg2", 0, 32'(d_gnt[0]), 1); chk("b_irv", 0, 32'(if_rvalid[0]), 1);
    chk("b_ird", 0, 32'(if_rdata[0]), 32'h1020);
    cyc(); d_req[0] = 1'b0;
    cyc();
    #1 chk("b_drv", 0, 32'(d_rvalid[0]), 1); chk("b_drd", 0, 32'(d_rdata[0]), 32'h1030);

    // Data write
    cyc(); d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 16'h0200; d_wdata[0] = 16'hBEEF;
    #1 chk("w_gnt", 0, 32'(d_gnt[0]), 1); chk("w_we", 0, 32'(mem_we[0]), 1);
    chk("w_wd", 0, 32'(mem_wdata[0]), 32'hBEEF); chk("w_addr", 0, 32'(mem_addr[0]), 32'h0200);
    cyc(); d_req[0] = 1'b0; d_we[0] = 1'b0;
    cyc();
    #1 chk("w_rv", 0, 32'(d_rvalid[0]), 1); chk("w_rd", 0, 32'(d_rdata[0]), 0);
    chk("w_irv", 0, 32'(if_rvalid[0]), 0);

    // Continuous contention: strict alternation starting with fetch
    cyc(); if_req[0] = 1'b1; if_addr[0] = 16'h0060; d_req[0] = 1'b1; d_addr[0] = 16'h0070;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) cyc();
      #1;
      chk("c_en", i, 32'(mem_en[0]), 32'(i % 2 == 0));
      chk("c_ig", i, 32'(if_gnt[0]), 32'(i % 4 == 0));
      chk("c_dg", i, 32'(d_gnt[0]), 32'(i % 4 == 2));
    end
    cyc(); if_req[0] = 1'b0; d_req[0] = 1'b0;
    cyc();

    // Reset mid-transaction drops the response
    cyc(); if_req[0] = 1'b1; if_addr[0] = 16'h0040;
    #1 chk("m_gnt", 0, 32'(if_gnt[0]), 1);
    cyc(); rst = 1'b1;
    #1 chk("m_ig", 0, 32'(if_gnt[0]), 0); chk("m_rv", 0, 32'(if_rvalid[0]), 0);
    chk("m_busy", 0, 32'(busy[0]), 0); chk("m_en", 0, 32'(mem_en[0]), 0);
    cyc(); rst = 1'b0;
    #1 chk("m_rv2", 0, 32'(if_rvalid[0]), 0); chk("m_gnt2", 0, 32'(if_gnt[0]), 1);
    chk("m_addr", 0, 32'(mem_addr[0]), 32'h0040);
    cyc(); if_req[0] = 1'b0;
    cyc(); cyc();

    // LATENCY=1 instance: grant and response every cycle
    for (int i = 0; i < 4; i++) begin
      cyc(); if_req[1] = 1'b1; if_addr[1] = 16'(16'h0050 + i);
      #1 chk("l_gnt", i, 32'(if_gnt[1]), 1);
      chk("l_addr", i, 32'(mem_addr[1]), 32'(16'h0050 + i));
      chk("l_rv", i, 32'(if_rvalid[1]), 32'(i > 0));
      if (i > 0) chk("l_rd", i, 32'(if_rdata[1]), 32'(16'h1050 + i - 1));
    end
    cyc(); if_req[1] = 1'b0;
    #1 chk("l_rv4", 0, 32'(if_rvalid[1]), 1); chk("l_rd4", 0, 32'(if_rdata[1]), 32'h1053);

    // Random traffic with occasional reset; requests held until granted
    for (int n = 0; n < 4000; n++) begin
      cyc();
      rst = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < 2; k++) begin
        if (!if_req[k] || sn_if[k]) begin
          if_req[k]  = ($urandom_range(0, 3) != 0);
          if_addr[k] = AW'($urandom);
        end
        if (!d_req[k] || sn_d[k]) begin
          d_req[k]   = ($urandom_range(0, 2) != 0);
          d_we[k]    = 1'($urandom_range(0, 1));
          d_addr[k]  = AW'($urandom);
          d_wdata[k] = DW'($urandom);
        end
      end
    end
    cyc(); rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if_req[k] = 1'b0; d_req[k] = 1'b0;
    end
    repeat (4) cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
